// File: rtl/md_sched_pkg.sv
// Shared encodings, default latencies and FSM states for the HI/LO multiply/divide sequencer.
// MD_SCHED_MADD_EN enables the MADD/MADDU accumulate ops (codes 7/8).
package md_sched_pkg;

    typedef enum logic [3:0] {
        OpNone  = 4'd0,
        OpMult  = 4'd1,
        OpMultu = 4'd2,
        OpDiv   = 4'd3,
        OpDivu  = 4'd4,
        OpMthi  = 4'd5,
        OpMtlo  = 4'd6,
        OpMadd  = 4'd7,
        OpMaddu = 4'd8
    } md_op_e;

    localparam int unsigned DefaultMultCycles = 5;
    localparam int unsigned DefaultDivCycles  = 10;

    typedef enum logic {
        StIdle,
        StBusy
    } md_state_e;

    // Ops that open a busy window and commit HI/LO at its end.
    function automatic logic is_long_op(logic [3:0] op);
        logic long_op;
        long_op = (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
`ifdef MD_SCHED_MADD_EN
        long_op = long_op || (op == OpMadd) || (op == OpMaddu);
`endif
        return long_op;
    endfunction

    function automatic logic is_div_op(logic [3:0] op);
        return (op == OpDiv) || (op == OpDivu);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit {HI,LO} result for a multiply/divide op; divide by zero holds HI/LO.
// MD_SCHED_MADD_EN adds the MADD/MADDU accumulate into the current HI/LO.
module md_calc
    import md_sched_pkg::*;
(
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [31:0] b_abs_nz;
    logic [31:0] b_nz;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'b0, A} * {32'b0, B};

    assign a_neg    = A[31];
    assign b_neg    = B[31];
    assign a_abs    = a_neg ? -A : A;
    assign b_abs    = b_neg ? -B : B;
    assign b_abs_nz = (b_abs == 32'd0) ? 32'd1 : b_abs;
    assign b_nz     = (B == 32'd0) ? 32'd1 : B;
    assign q_mag    = a_abs / b_abs_nz;
    assign r_mag    = a_abs % b_abs_nz;

    always_comb begin
        result = {hi, lo};
        case (md_op)
            OpMult:  result = prod_s;
            OpMultu: result = prod_u;
            OpDiv: begin
                if (B != 32'd0) begin
                    result = {(a_neg ? -r_mag : r_mag), ((a_neg ^ b_neg) ? -q_mag : q_mag)};
                end
            end
            OpDivu: begin
                if (B != 32'd0) begin
                    result = {A % b_nz, A / b_nz};
                end
            end
`ifdef MD_SCHED_MADD_EN
            OpMadd:  result = {hi, lo} + prod_s;
            OpMaddu: result = {hi, lo} + prod_u;
`endif
            default: result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; result is latched at issue and committed
// after a fixed busy window. MD_SCHED_MADD_EN enables MADD/MADDU.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DefaultMultCycles,
    parameter int unsigned DIV_CYCLES  = DefaultDivCycles
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] calc_result;
    logic [3:0]  op_cycles;

    md_calc u_md_calc (
        .md_op  (md_op),
        .A      (A),
        .B      (B),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (calc_result)
    );

    assign op_cycles = is_div_op(md_op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_long_op(md_op)) begin
                        pend_d  = calc_result;
                        cnt_d   = op_cycles;
                        state_d = StBusy;
                    end else if (md_op == OpMthi) begin
                        hi_d = A;
                    end else if (md_op == OpMtlo) begin
                        lo_d = A;
                    end
                end
            end
            StBusy: begin
                // start is ignored here; the hazard unit stalls issue while busy.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = pend_q[63:32];
                    lo_d    = pend_q[31:0];
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            pend_q  <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == StBusy);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed cases plus random ops against an arithmetic model.
// Define MD_SCHED_MADD_EN for both bench and RTL to exercise MADD/MADDU.
module tb_md_sched;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    md_sched #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: latency and resulting {HI,LO} from the architectural rules.
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int n, output logic [63:0] res);
        longint sa, sb, ua, ub, q, r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        res = {m_hi, m_lo};
        n   = 0;
        case (op)
            4'd1: begin res = sa * sb; n = MC; end
            4'd2: begin res = ua * ub; n = MC; end
            4'd3: begin
                n = DC;
                if (b != 0) begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            4'd4: begin
                n = DC;
                if (b != 0) begin
                    q   = ua / ub;
                    r   = ua % ub;
                    res = {r[31:0], q[31:0]};
                end
            end
            4'd5: res = {a, m_lo};
            4'd6: res = {m_hi, a};
`ifdef MD_SCHED_MADD_EN
            4'd7: begin res = {m_hi, m_lo} + sa * sb; n = MC; end
            4'd8: begin res = {m_hi, m_lo} + ua * ub; n = MC; end
`endif
            default: ;
        endcase
    endtask

    // Entered and left at a negedge; successive calls issue back-to-back.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int n;
        logic [63:0] res;
        check({tag, "/idle_at_issue"}, 64'(busy), 64'd0);
        model_op(op, a, b, n, res);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        md_op = 4'd0;
        for (int i = 0; i < n; i++) begin
            check({tag, "/busy"}, 64'(busy), 64'd1);
            check({tag, "/hold"}, {HI, LO}, {m_hi, m_lo});
            @(negedge clk);
        end
        check({tag, "/done"}, 64'(busy), 64'd0);
        check({tag, "/hilo"}, {HI, LO}, res);
        m_hi = res[63:32];
        m_lo = res[31:0];
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 4));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        md_op = 4'd0;
        A     = 32'd0;
        B     = 32'd0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        #3;
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-MULT discards the pending result.
        run_op("mthi_pre", 4'd5, 32'h0000_0055, 32'd0);
        start = 1'b1; md_op = 4'd1; A = 32'd3; B = 32'd4;
        @(negedge clk);
        start = 1'b0; md_op = 4'd0;
        check("rst_mid/busy_pre", 64'(busy), 64'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid/busy", 64'(busy), 64'd0);
        check("rst_mid/hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        for (int i = 0; i < 8; i++) begin
            check("rst_mid/no_commit", {31'd0, busy, HI, LO}, 64'd0);
            @(negedge clk);
        end

        run_op("mult_s", 4'd1, 32'hFFFF_FFFF, 32'd2);
        check("mult_s/abs", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2);
        check("multu/abs", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
        run_op("div_s", 4'd3, 32'hFFFF_FFF9, 32'd2);
        check("div_s/abs", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf/abs", {HI, LO}, 64'h0000_0000_8000_0000);
        run_op("mthi11", 4'd5, 32'h11, 32'd0);
        run_op("mtlo22", 4'd6, 32'h22, 32'd0);
        run_op("divu0", 4'd4, 32'h1234_5678, 32'd0);
        check("divu0/abs", {HI, LO}, 64'h0000_0011_0000_0022);
        run_op("mthi_dead", 4'd5, 32'hDEAD_BEEF, 32'd0);
        check("mthi_dead/abs", 64'(HI), 64'hDEAD_BEEF);
        run_op("b2b_mtlo", 4'd6, 32'hCAFE_F00D, 32'd0);
        run_op("b2b_mult", 4'd1, 32'd6, 32'd7);
        check("b2b_mult/abs", {HI, LO}, 64'd42);
        run_op("none", 4'd0, 32'h1, 32'h1);
        run_op("illegal", 4'd15, 32'h1, 32'h1);

        run_op("madd_hi0", 4'd5, 32'd0, 32'd0);
        run_op("madd_loff", 4'd6, 32'hFFFF_FFFF, 32'd0);
        run_op("maddu", 4'd8, 32'd1, 32'd1);
`ifdef MD_SCHED_MADD_EN
        check("maddu/abs", {HI, LO}, 64'h0000_0001_0000_0000);
`else
        check("maddu/abs", {HI, LO}, 64'h0000_0000_FFFF_FFFF);
`endif

        for (int k = 0; k < 60; k++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(1, 8));
            run_op($sformatf("rand%0d_op%0d", k, op), op, rand_word(), rand_word());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide sequencer attached to the execute stage of the 5-stage MIPS pipeline.
- Owns the HI/LO register pair and accepts one operation per issue.
- Holds a busy window of fixed length, then commits the result; the hazard unit uses busy/start to stall dependent MD instructions and mfhi/mflo.
- Operands arrive already forwarded, i.e. the selected RS/RT values.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MADDU when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  E-stage MD instruction valid this cycle; one-cycle pulse per instruction
- md_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU; others NONE
- A  in  32  forwarded RS value
- B  in  32  forwarded RT value
- busy  out  1  high while an operation is in flight
- HI  out  32  current HI register
- LO  out  32  current LO register

Behaviour:
- Reset (async): state IDLE, counter 0, HI=0, LO=0, busy=0; an in-flight operation is discarded, with no commit after reset deasserts.
- States: IDLE, BUSY.
- IDLE + start + op in {MULT,MULTU,DIV,DIVU}:
  - at that edge, compute the 64-bit result and latch it in pending_hi/pending_lo;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - go to BUSY.
- BUSY:
  - counter decrements each edge;
  - on the edge where the counter goes 1->0: HI<=pending_hi, LO<=pending_lo, state IDLE.
  - busy=1 for exactly N cycles after the start edge (N = cycle parameter), and is registered.
- HI/LO hold old values during BUSY. New values are visible the cycle busy falls.
- MTHI/MTLO in IDLE: write HI (resp. LO) <= A at the start edge. Busy is not asserted; the value is visible the next cycle.
- start while BUSY: ignored entirely. The pipeline guarantees the stall, so this case is a protocol violation; the bench asserts it never occurs in legal flows.
- Start with md_op NONE/illegal: no effect.
- Arithmetic:
  - MULT signed 32x32->64, MULTU unsigned; HI = upper word, LO = lower word.
  - DIV signed: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU unsigned.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
  - Divide by zero: the busy window still runs, and HI/LO are unchanged at commit (pending := current HI/LO).
- Stall contract for the hazard unit: stall D when (busy|start) and the D-stage instruction is an MD op or mfhi/mflo. The block itself does not drive stall.

Optional Feature:
- Macro: MD_SCHED_MADD_EN.
- Defined:
  - md_op 7/8 are accepted: {HI,LO} <= {HI,LO} + A*B (signed / unsigned product), mod 2^64.
  - The sum uses the HI/LO values at the start edge and commits after MULT_CYCLES cycles like MULT.
- Undefined: codes 7/8 are treated as NONE, with no busy and no state change.

Decomposition:
- Package md_sched_pkg:
  - md_op encodings;
  - default cycle counts;
  - state enum (IDLE, BUSY).
- One sub-module, md_calc: combinational 64-bit result from (md_op, A, B, HI, LO), including the divide-by-zero hold and the MADD accumulate. This keeps md_sched purely sequencing and state.

Test Plan:
- Reset mid-MULT: start MULT A=3,B=4, assert reset after 2 cycles -> HI=0, LO=0, busy=0 immediately, and no later commit.
- MULT signed: A=0xFFFFFFFF (-1), B=2 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV signed: A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Edge case 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU by zero with HI=0x11, LO=0x22 -> busy 10 cycles, HI/LO unchanged.
- MTHI A=0xDEADBEEF in IDLE -> busy stays 0 and HI=0xDEADBEEF next cycle. Back-to-back: MTLO then MULT on the next cycle -> the MULT result overwrites both at commit.
- With MD_SCHED_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU A=1,B=1 -> after 5 cycles HI=1, LO=0. Without the macro, the same op leaves HI/LO untouched and busy stays 0.
